// File: rtl/siren_pkg.sv
// ---------------------------------------------------------------------------
// siren_pkg
// Shared types and helpers for the siren LED sequencer.
//   mode_e      : requested/active flash pattern (OFF, ALT, STROBE, BOTH)
//   state_e     : sequencer FSM state (IDLE, RUN)
//   LAST_*      : index of the final step of each pattern (pattern length - 1)
//   lastStep()  : final step index for a given mode
//   decodeLeds(): {led_r, led_b} for a given mode and step
// ---------------------------------------------------------------------------
package siren_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ALT    = 2'd1,
    MODE_STROBE = 2'd2,
    MODE_BOTH   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Pattern lengths are 2, 8 and 2 steps; we store the last index so it fits in 3 bits.
  localparam logic [2:0] LAST_ALT    = 3'd1;
  localparam logic [2:0] LAST_STROBE = 3'd7;
  localparam logic [2:0] LAST_BOTH   = 3'd1;

  function automatic logic [2:0] lastStep(input mode_e m);
    case (m)
      MODE_ALT:    return LAST_ALT;
      MODE_STROBE: return LAST_STROBE;
      MODE_BOTH:   return LAST_BOTH;
      default:     return 3'd0;
    endcase
  endfunction

  // Returns {led_r, led_b}. STROBE flashes red twice, then blue twice,
  // with a dark step between each flash.
  function automatic logic [1:0] decodeLeds(input mode_e m, input logic [2:0] s);
    case (m)
      MODE_ALT:    return s[0] ? 2'b01 : 2'b10;
      MODE_BOTH:   return s[0] ? 2'b00 : 2'b11;
      MODE_STROBE: return s[0] ? 2'b00 : (s[2] ? 2'b01 : 2'b10);
      default:     return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/siren_pattern_ctrl_if.sv
// ---------------------------------------------------------------------------
// siren_pattern_ctrl_if
// Mode request handshake plus status/LED outputs of the siren sequencer.
//   en, mode, mode_valid     : driven by the mode source (master)
//   mode_ack, busy, step,
//   led_r, led_b             : driven by the sequencer (slave)
// ---------------------------------------------------------------------------
interface siren_pattern_ctrl_if;
  logic       en;
  logic [1:0] mode;
  logic       mode_valid;
  logic       mode_ack;
  logic       busy;
  logic [2:0] step;
  logic       led_r;
  logic       led_b;

  modport master (
    output en, mode, mode_valid,
    input  mode_ack, busy, step, led_r, led_b
  );

  modport slave (
    input  en, mode, mode_valid,
    output mode_ack, busy, step, led_r, led_b
  );
endinterface

// File: rtl/siren_tick_gen.sv
// ---------------------------------------------------------------------------
// siren_tick_gen
// Step prescaler: counts 0..CLK_DIV-1 while enabled and pulses tick_o on the
// cycle the count sits at CLK_DIV-1.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : hold the count at 0 (sequencer idle)
//   en_i     : count enable; when low the count is frozen and no tick is issued
//   tick_o   : one-cycle step tick
// ---------------------------------------------------------------------------
module siren_tick_gen #(
  parameter int CLK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/siren_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// siren_pattern_ctrl
// Red/blue siren sequencer. Walks the active flash pattern one step per
// prescaler tick; new modes are accepted via a valid/ack handshake and only
// take effect at the end of the current pattern.
//   clk, rst : clock, synchronous active-high reset
//   ctrl_io  : siren_pattern_ctrl_if.slave (en, mode, mode_valid in;
//              mode_ack, busy, step, led_r, led_b out)
// ---------------------------------------------------------------------------
module siren_pattern_ctrl
  import siren_pkg::*;
#(
  parameter int CLK_DIV = 12_500_000
) (
  input  logic                 clk,
  input  logic                 rst,
  siren_pattern_ctrl_if.slave  ctrl_io
);

  state_e     state_q, state_d;
  mode_e      curMode_q, curMode_d;
  mode_e      pendMode_q, pendMode_d;
  logic       pendValid_q, pendValid_d;
  logic [2:0] step_q, step_d;
  logic       ack_q, ack_d;
  logic       tick;
  logic       reqValid;
  mode_e      reqMode;
  logic [1:0] leds;

  siren_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == ST_IDLE),
    .en_i   (ctrl_io.en),
    .tick_o (tick)
  );

  // A request arriving in the same cycle it would be accepted beats the stored one.
  assign reqValid = ctrl_io.mode_valid || pendValid_q;
  assign reqMode  = ctrl_io.mode_valid ? mode_e'(ctrl_io.mode) : pendMode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      curMode_q   <= MODE_OFF;
      pendMode_q  <= MODE_OFF;
      pendValid_q <= 1'b0;
      step_q      <= 3'd0;
      ack_q       <= 1'b0;
    end else begin
      curMode_q   <= curMode_d;
      pendMode_q  <= pendMode_d;
      pendValid_q <= pendValid_d;
      step_q      <= step_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    curMode_d   = curMode_q;
    pendMode_d  = pendMode_q;
    pendValid_d = pendValid_q;
    step_d      = step_q;
    ack_d       = 1'b0;

    if (ctrl_io.mode_valid) begin
      pendMode_d  = mode_e'(ctrl_io.mode);
      pendValid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          ack_d       = 1'b1;
          pendValid_d = 1'b0;
          curMode_d   = reqMode;
          step_d      = 3'd0;
          if (reqMode != MODE_OFF) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (step_q != lastStep(curMode_q)) begin
            step_d = step_q + 3'd1;
          end else begin
            // Pattern boundary: the only point where a pending mode may land.
            step_d = 3'd0;
            if (reqValid) begin
              ack_d       = 1'b1;
              pendValid_d = 1'b0;
              curMode_d   = reqMode;
              if (reqMode == MODE_OFF) state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // LEDs come only from registered mode/step so input glitches never reach the pins.
  always_comb begin
    leds = decodeLeds(curMode_q, step_q);
  end

  assign ctrl_io.busy     = (state_q == ST_RUN);
  assign ctrl_io.mode_ack = ack_q;
  assign ctrl_io.step     = step_q;
  assign ctrl_io.led_r    = leds[1];
  assign ctrl_io.led_b    = leds[0];

endmodule

// File: tb/tb_siren_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// tb_siren_pattern_ctrl
// Segment table for siren_pattern_ctrl with CLK_DIV=4. Each record holds the
// inputs for a run of cycles (mode_valid only on the first cycle) and the
// outputs expected at the end of it, including how many mode_ack pulses
// should have appeared during the run.
// ---------------------------------------------------------------------------
module tb_siren_pattern_ctrl;

  localparam int CLK_DIV = 4;
  localparam logic [1:0] M_OFF = 2'd0, M_ALT = 2'd1, M_STROBE = 2'd2, M_BOTH = 2'd3;

  typedef struct {
    bit         rst;
    bit         en;
    logic [1:0] mode;
    bit         valid;
    int         cycles;
    int         acks;
    bit         busy;
    logic [2:0] step;
    bit         ledR;
    bit         ledB;
  } vec_t;

  typedef struct {
    string      name;
    int         acks;
    bit         busy;
    logic [2:0] step;
    bit         ledR;
    bit         ledB;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  vec_t vecs[$];
  exp_t sbQ[$];
  int   checks = 0;
  int   passes = 0;
  int   ackCnt = 0;

  always #5 clk = ~clk;

  siren_pattern_ctrl_if ctrlIf ();

  siren_pattern_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (ctrlIf)
  );

  function automatic void addVec(bit r, bit e, logic [1:0] m, bit v, int n,
                                 int a, bit b, logic [2:0] s, bit lr, bit lb);
    vec_t x;
    x.rst = r; x.en = e; x.mode = m; x.valid = v; x.cycles = n;
    x.acks = a; x.busy = b; x.step = s; x.ledR = lr; x.ledB = lb;
    vecs.push_back(x);
  endfunction

  // Drive one segment, queue its expectation, and count ack pulses seen.
  task automatic applyStimulus(input vec_t v, input string name);
    exp_t x;
    x.name = name; x.acks = v.acks; x.busy = v.busy;
    x.step = v.step; x.ledR = v.ledR; x.ledB = v.ledB;
    sbQ.push_back(x);
    rst               = v.rst;
    ctrlIf.en         = v.en;
    ctrlIf.mode       = v.mode;
    ctrlIf.mode_valid = v.valid;
    ackCnt            = 0;
    for (int i = 0; i < v.cycles; i++) begin
      @(posedge clk);
      #1;
      ctrlIf.mode_valid = 1'b0;
      @(negedge clk);
      if (ctrlIf.mode_ack === 1'b1) ackCnt++;
    end
  endtask

  task automatic checkOutput();
    exp_t x;
    checks++;
    if (sbQ.size() == 0) begin
      $display("[TB] FAIL scoreboard: got empty queue, expected one entry");
      return;
    end
    x = sbQ.pop_front();
    if (ackCnt == x.acks && ctrlIf.busy === x.busy && ctrlIf.step === x.step &&
        ctrlIf.led_r === x.ledR && ctrlIf.led_b === x.ledB) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got acks=%0d busy=%b step=%0d led_rb=%b%b, expected acks=%0d busy=%b step=%0d led_rb=%b%b",
               x.name, ackCnt, ctrlIf.busy, ctrlIf.step, ctrlIf.led_r, ctrlIf.led_b,
               x.acks, x.busy, x.step, x.ledR, x.ledB);
    end
  endtask

  initial begin
    vec_t r;

    // Reset held 3 cycles, checked after every cycle.
    r.rst = 1; r.en = 1; r.mode = M_OFF; r.valid = 0; r.cycles = 1;
    r.acks = 0; r.busy = 0; r.step = 0; r.ledR = 0; r.ledB = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(r, $sformatf("reset_c%0d", i));
      checkOutput();
    end

    //     rst en mode      vld n  ack busy step r b
    addVec(0, 1, M_OFF,    0, 2,  0, 0, 0, 0, 0);   // idle after reset
    addVec(0, 1, M_ALT,    1, 1,  1, 1, 0, 1, 0);   // ALT accepted, ack next cycle
    addVec(0, 1, M_OFF,    0, 3,  0, 1, 0, 1, 0);   // prescaler at 3, no step yet
    addVec(0, 1, M_OFF,    0, 1,  0, 1, 1, 0, 1);   // 4th clk: step 1
    addVec(0, 1, M_OFF,    0, 4,  0, 1, 0, 1, 0);   // wraps to step 0
    addVec(0, 1, M_STROBE, 1, 4,  0, 1, 1, 0, 1);   // pending, no change mid-pattern
    addVec(0, 1, M_OFF,    0, 4,  1, 1, 0, 1, 0);   // boundary: STROBE step 0
    addVec(0, 1, M_OFF,    0, 4,  0, 1, 1, 0, 0);
    addVec(0, 1, M_OFF,    0, 4,  0, 1, 2, 1, 0);
    addVec(0, 1, M_OFF,    0, 4,  0, 1, 3, 0, 0);
    addVec(0, 1, M_BOTH,   1, 1,  0, 1, 3, 0, 0);   // request BOTH
    addVec(0, 1, M_OFF,    1, 1,  0, 1, 3, 0, 0);   // then OFF overwrites it
    addVec(0, 1, M_OFF,    0, 2,  0, 1, 4, 0, 1);
    addVec(0, 1, M_OFF,    0, 4,  0, 1, 5, 0, 0);
    addVec(0, 1, M_OFF,    0, 4,  0, 1, 6, 0, 1);
    addVec(0, 1, M_OFF,    0, 4,  0, 1, 7, 0, 0);
    addVec(0, 1, M_OFF,    0, 4,  1, 0, 0, 0, 0);   // OFF lands at boundary -> IDLE
    addVec(0, 1, M_OFF,    0, 4,  0, 0, 0, 0, 0);   // only one ack was issued
    addVec(0, 1, M_ALT,    1, 1,  1, 1, 0, 1, 0);   // ALT again
    addVec(0, 1, M_OFF,    0, 2,  0, 1, 0, 1, 0);   // prescaler now at 2
    for (int i = 0; i < 10; i++)
      addVec(0, 0, M_OFF,  0, 1,  0, 1, 0, 1, 0);   // paused: frozen
    addVec(0, 1, M_OFF,    0, 1,  0, 1, 0, 1, 0);   // resume: count 3
    addVec(0, 1, M_OFF,    0, 1,  0, 1, 1, 0, 1);   // tick from frozen count
    addVec(0, 1, M_BOTH,   1, 4,  1, 1, 0, 1, 1);   // BOTH at ALT boundary
    addVec(0, 1, M_OFF,    0, 4,  0, 1, 1, 0, 0);   // BOTH step 1
    addVec(0, 1, M_ALT,    1, 1,  0, 1, 1, 0, 0);   // pending ALT
    addVec(1, 1, M_OFF,    0, 1,  0, 0, 0, 0, 0);   // reset mid-pattern
    addVec(0, 1, M_OFF,    0, 8,  0, 0, 0, 0, 0);   // pending lost, no ack
    addVec(0, 1, M_OFF,    1, 1,  1, 0, 0, 0, 0);   // OFF in IDLE: ack, stay idle
    addVec(0, 1, M_BOTH,   1, 1,  1, 1, 0, 1, 1);   // BOTH
    addVec(0, 1, M_OFF,    0, 4,  0, 1, 1, 0, 0);
    addVec(0, 1, M_ALT,    1, 1,  0, 1, 1, 0, 0);   // pending ALT
    addVec(0, 1, M_OFF,    0, 2,  0, 1, 1, 0, 0);   // tick active next cycle
    addVec(0, 1, M_STROBE, 1, 1,  1, 1, 0, 1, 0);   // same-cycle request wins
    addVec(0, 1, M_OFF,    0, 4,  0, 1, 1, 0, 0);   // STROBE step 1, not ALT

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
